traffic_phase_scheduler: RTL
============================

Name: traffic_phase_scheduler

Overview:
- Demand-driven phase scheduler for a two-road intersection: road 1 is the main road, road 2 is the side road.
- Sequences the six lamp outputs through startup, green/yellow/all-red phases, pedestrian walk windows, an emergency preemption and a night flashing mode.
- Sits between the intersection sensors/buttons and the lamp drivers. It supersedes fixed-time sequencing with actuated timing.

Parameters:
- CNT_W, 12, phase counter width. Every T_* value must be ≤ 2^CNT_W−1 and ≥ 1.
- T_START, 250, all-yellow startup dwell (cycles).
- T_G1MIN, 1500, minimum road-1 green.
- T_G1MAX, 3000, maximum road-1 green while road-2 demand is absent. Must be ≥ T_G1MIN.
- T_Y, 250, yellow dwell, used for both roads.
- T_AR, 50, all-red clearance dwell.
- T_G2, 2000, road-2 green dwell.
- T_WALK, 800, walk window length. Must be ≤ T_G1MIN and ≤ T_G2.
- T_FLASH, 10, night flash half-period.

Ports:
- clk  in  1  sole clock.
- ret  in  1  synchronous, active-high reset.
- car_sense2  in  1  road-2 vehicle detector (level).
- ped_req1  in  1  pedestrian button for crossing alongside road 1 (pulse, latched).
- ped_req2  in  1  pedestrian button for crossing alongside road 2 (pulse, latched).
- emergency  in  1  preempt to road-1 green (level).
- night  in  1  night flashing mode request (level).
- red1, yellow1, green1  out  1 each  road-1 lamps (registered).
- red2, yellow2, green2  out  1 each  road-2 lamps (registered).
- walk1, walk2  out  1 each  pedestrian walk lamps (registered).
- phase  out  3  current state encoding (registered).

Behaviour:
- Clock and reset: one clock, clk. Reset ret is synchronous and active-high. All registers update on the posedge of clk only.
- Reset values (ret=1 at a clock edge, including mid-phase):
  - phase=START(0), count=0.
  - yellow1=yellow2=1; all other lamps, walk1, walk2 and both pedestrian latches = 0.
- State encoding: START=0, G1=1, Y1=2, AR1=3, G2=4, Y2=5, AR2=6, FLASH=7.
- Lamps are a registered decode of the state entered on the same edge, so outputs always match phase:
  - START: Y1+Y2. G1: G1+R2. Y1: Y1+R2. AR1, AR2: R1+R2. G2: R1+G2. Y2: R1+Y2.
  - FLASH: red lamps off, green lamps off; yellow1=yellow2=flash bit.
- Counter: count is 0 in the first cycle of every state and increments by 1 each cycle. In G1 while emergency=1, count saturates at T_G1MAX−1 instead of wrapping.
- Exit condition "done(T)" means count==T−1, giving a dwell of exactly T cycles.
- Transitions:
  - START → G1 on done(T_START).
  - G1 → Y1 when emergency=0 AND (done(T_G1MAX) OR (count ≥ T_G1MIN−1 AND demand2)).
    - demand2 = car_sense2 | ped_latch2 | ped_req2.
    - While emergency=1, G1 is held.
  - Y1 → AR1 on done(T_Y).
  - AR1 → G2 on done(T_AR).
  - G2 → Y2 on done(T_G2), or on the first edge where emergency=1 (count reset to 0).
  - Y2 → AR2 on done(T_Y).
  - AR2 → FLASH if night=1 at done(T_AR); otherwise AR2 → G1 at done(T_AR).
  - FLASH: the flash bit starts at 1 and toggles at every done(T_FLASH), with count restarting at 0.
    - FLASH → AR2 at done(T_FLASH) when night=0, then AR2 → G1.
    - emergency is ignored in FLASH.
  - Y1, AR1, Y2 and AR2 always complete their dwell, regardless of emergency.
- Pedestrian latches:
  - ped_latchN is set by ped_reqN.
  - On the edge entering GN, walkN is set if (ped_latchN | ped_reqN), and ped_latchN is cleared in the same cycle; clear wins over a simultaneous request.
  - walkN clears when count==T_WALK−1 in GN, or on exit from GN, whichever comes first. walkN is never 1 outside GN.
  - A request arriving mid-GN is latched and served at the next GN entry.
- A FLASH entry/exit takes precedence over pending pedestrian demand; latches are retained through FLASH.

Test Plan:
Bench overrides: T_START=4, T_G1MIN=6, T_G1MAX=10, T_Y=3, T_AR=2, T_G2=5, T_WALK=3, T_FLASH=2.
- Reset, then hold inputs low:
  - START for 4 cycles with Y1=Y2=1.
  - G1 for 10 cycles (max), then Y1 ×3, AR1 ×2, G2 ×5, Y2 ×3, AR2 ×2, back to G1.
  - phase sequence is 0,1,2,3,4,5,6,1.
- car_sense2=1 from G1 cycle 0 → G1 lasts exactly 6 cycles, then Y1. Raising car_sense2 at G1 cycle 8 → Y1 on the next edge.
- ped_req1 pulse during G2 → walk1=1 for the first 3 cycles of the next G1, then 0.
  - A ped_req1 pulse coincident with G1 entry → walk1 is served, and the latch is 0 afterwards.
- emergency=1 at G2 cycle 1 → Y2 on the next edge. Holding emergency → G1 is held indefinitely (count saturates at 9). Dropping emergency with demand2=1 → Y1 on the next edge.
- night=1 during G2 → completes Y2, AR2, then FLASH with yellows toggling 1,1,0,0,1,1… Dropping night → AR2 ×2, then G1.
- ret=1 mid-Y1 with ped_latch2 set → the next cycle shows phase=0, Y1=Y2=1, walk=0, latches cleared.

Source files
------------

// File: rtl/traffic_phase_scheduler.sv
// Actuated two-road intersection phase scheduler with pedestrian walk
// windows, emergency preemption to road-1 green and night flashing mode.
module traffic_phase_scheduler #(
  parameter int CNT_W   = 12,
  parameter int T_START = 250,
  parameter int T_G1MIN = 1500,
  parameter int T_G1MAX = 3000,
  parameter int T_Y     = 250,
  parameter int T_AR    = 50,
  parameter int T_G2    = 2000,
  parameter int T_WALK  = 800,
  parameter int T_FLASH = 10
) (
  input  logic       clk,
  input  logic       ret,
  input  logic       car_sense2,
  input  logic       ped_req1,
  input  logic       ped_req2,
  input  logic       emergency,
  input  logic       night,
  output logic       red1,
  output logic       yellow1,
  output logic       green1,
  output logic       red2,
  output logic       yellow2,
  output logic       green2,
  output logic       walk1,
  output logic       walk2,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    START = 3'd0, G1 = 3'd1, Y1 = 3'd2, AR1 = 3'd3,
    G2    = 3'd4, Y2 = 3'd5, AR2 = 3'd6, FLASH = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] D_START = CNT_W'(T_START - 1);
  localparam logic [CNT_W-1:0] D_G1MIN = CNT_W'(T_G1MIN - 1);
  localparam logic [CNT_W-1:0] D_G1MAX = CNT_W'(T_G1MAX - 1);
  localparam logic [CNT_W-1:0] D_Y     = CNT_W'(T_Y - 1);
  localparam logic [CNT_W-1:0] D_AR    = CNT_W'(T_AR - 1);
  localparam logic [CNT_W-1:0] D_G2    = CNT_W'(T_G2 - 1);
  localparam logic [CNT_W-1:0] D_WALK  = CNT_W'(T_WALK - 1);
  localparam logic [CNT_W-1:0] D_FLASH = CNT_W'(T_FLASH - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             flash, flash_nxt;
  logic             ped_latch1, ped_latch2;
  logic             walk1_nxt, walk2_nxt;
  logic             enter1, enter2, demand2;

  // Lamp pattern {red1,yellow1,green1,red2,yellow2,green2} for a state.
  function automatic logic [5:0] lamp_decode(input state_t s, input logic f);
    case (s)
      START:    lamp_decode = 6'b010_010;
      G1:       lamp_decode = 6'b001_100;
      Y1:       lamp_decode = 6'b010_100;
      AR1, AR2: lamp_decode = 6'b100_100;
      G2:       lamp_decode = 6'b100_001;
      Y2:       lamp_decode = 6'b100_010;
      FLASH:    lamp_decode = {1'b0, f, 1'b0, 1'b0, f, 1'b0};
      default:  lamp_decode = 6'b010_010;
    endcase
  endfunction

  assign phase   = state;
  assign demand2 = car_sense2 | ped_latch2 | ped_req2;

  // Next state, phase counter and flash bit.
  always_comb begin
    state_nxt = state;
    count_nxt = count + ONE;
    flash_nxt = flash;
    case (state)
      START: begin
        if (count == D_START) begin
          state_nxt = G1;
          count_nxt = '0;
        end else begin
          state_nxt = START;
        end
      end
      G1: begin
        if (emergency) begin
          // Held green: count parks at the max-green mark until release.
          if (count == D_G1MAX) count_nxt = count;
          else                  count_nxt = count + ONE;
        end else if (count == D_G1MAX || (count >= D_G1MIN && demand2)) begin
          state_nxt = Y1;
          count_nxt = '0;
        end else begin
          state_nxt = G1;
        end
      end
      Y1: begin
        if (count == D_Y) begin
          state_nxt = AR1;
          count_nxt = '0;
        end else begin
          state_nxt = Y1;
        end
      end
      AR1: begin
        if (count == D_AR) begin
          state_nxt = G2;
          count_nxt = '0;
        end else begin
          state_nxt = AR1;
        end
      end
      G2: begin
        if (emergency || count == D_G2) begin
          state_nxt = Y2;
          count_nxt = '0;
        end else begin
          state_nxt = G2;
        end
      end
      Y2: begin
        if (count == D_Y) begin
          state_nxt = AR2;
          count_nxt = '0;
        end else begin
          state_nxt = Y2;
        end
      end
      AR2: begin
        if (count == D_AR) begin
          count_nxt = '0;
          if (night) begin
            state_nxt = FLASH;
            flash_nxt = 1'b1;
          end else begin
            state_nxt = G1;
          end
        end else begin
          state_nxt = AR2;
        end
      end
      FLASH: begin
        if (count == D_FLASH) begin
          count_nxt = '0;
          if (night) flash_nxt = ~flash;
          else       state_nxt = AR2;
        end else begin
          state_nxt = FLASH;
        end
      end
      default: begin
        state_nxt = START;
        count_nxt = '0;
      end
    endcase
  end

  // Walk windows open on green entry and close at the walk mark or on exit.
  always_comb begin
    enter1 = (state_nxt == G1) && (state != G1);
    enter2 = (state_nxt == G2) && (state != G2);
    if (enter1)                 walk1_nxt = ped_latch1 | ped_req1;
    else if (state_nxt != G1)   walk1_nxt = 1'b0;
    else if (count == D_WALK)   walk1_nxt = 1'b0;
    else                        walk1_nxt = walk1;
    if (enter2)                 walk2_nxt = ped_latch2 | ped_req2;
    else if (state_nxt != G2)   walk2_nxt = 1'b0;
    else if (count == D_WALK)   walk2_nxt = 1'b0;
    else                        walk2_nxt = walk2;
  end

  // State, counter, pedestrian latches and registered lamp outputs.
  always_ff @(posedge clk) begin
    if (ret) begin
      state      <= START;
      count      <= '0;
      flash      <= 1'b0;
      ped_latch1 <= 1'b0;
      ped_latch2 <= 1'b0;
      walk1      <= 1'b0;
      walk2      <= 1'b0;
      {red1, yellow1, green1, red2, yellow2, green2} <= 6'b010_010;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      flash      <= flash_nxt;
      ped_latch1 <= enter1 ? 1'b0 : (ped_latch1 | ped_req1);
      ped_latch2 <= enter2 ? 1'b0 : (ped_latch2 | ped_req2);
      walk1      <= walk1_nxt;
      walk2      <= walk2_nxt;
      {red1, yellow1, green1, red2, yellow2, green2} <= lamp_decode(state_nxt, flash_nxt);
    end
  end

endmodule
